alu_status_stage: RTL and testbench

Registered execute stage directly downstream of the datapath shifter.
- Takes operand A (register-file side) and operand B (shifter output), performs ADD/SUB/AND/MVN.
- Holds the 16-bit result C in an output register.
- Optionally updates a 3-bit status register {Z,N,V}.
- Uses valid/ready on both sides, so the writeback path or the FSM controller can stall it without losing a result.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_status_stage_if.sv | 30 +++
 rtl/alu_core.sv | 38 +++
 rtl/alu_status_stage.sv | 84 ++++++++
 tb/tb_alu_status_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage and its combinational core.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } aluop_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

  // Bit positions inside the {Z,N,V} status word
  localparam int ST_Z = 2;
  localparam int ST_N = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/alu_status_stage_if.sv
// Operand-side and result-side valid/ready bundle of the ALU execute stage.
interface alu_status_stage_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  aluop_t           aluop;
  logic             loads;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [2:0]       status;

  // master: producer of operands and consumer of results
  modport master (
    output in_valid, ain, bin, aluop, loads, out_ready,
    input  in_ready, out_valid, c, status
  );

  // slave: the execute stage itself
  modport slave (
    input  in_valid, ain, bin, aluop, loads, out_ready,
    output in_ready, out_valid, c, status
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: ADD/SUB/AND/MVN with zero, negative and signed-overflow flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  aluop_t           aluop,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    r = '0;
    v = 1'b0;
    case (aluop)
      ALU_ADD: begin
        r = ain + bin;
        v = (ain[MSB] == bin[MSB]) & (r[MSB] != ain[MSB]);
      end
      ALU_SUB: begin
        r = ain - bin;
        v = (ain[MSB] != bin[MSB]) & (r[MSB] != ain[MSB]);
      end
      ALU_AND: r = ain & bin;
      ALU_MVN: r = ~bin;
      default: r = 'x;
    endcase
    z = (r == '0);
    n = r[MSB];
  end

endmodule

// File: rtl/alu_status_stage.sv
// Registered execute stage: one-entry result buffer with valid/ready on both sides
// and an optionally updated {Z,N,V} status register.
module alu_status_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_status_stage_if.slave bus
);

  stage_state_t     state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] c_reg;
  logic [2:0]       status_reg;

  logic [WIDTH-1:0] r;
  logic             z;
  logic             n;
  logic             v;
  logic [2:0]       flags_next;
  logic             accept;
  logic             take;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .ain   (bus.ain),
    .bin   (bus.bin),
    .aluop (bus.aluop),
    .r     (r),
    .z     (z),
    .n     (n),
    .v     (v)
  );

  always_comb begin
    flags_next       = '0;
    flags_next[ST_Z] = z;
    flags_next[ST_N] = n;
    flags_next[ST_V] = v;
  end

  // Ready passes straight through from the consumer so a draining sink sees no bubble
  assign bus.in_ready  = ~out_valid_reg | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign take          = out_valid_reg & bus.out_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.c         = c_reg;
  assign bus.status    = status_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      status_reg    <= '0;
    end else begin
      if (accept) begin
        c_reg <= r;
        if (bus.loads) status_reg <= flags_next;
      end
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg     <= FULL;
            out_valid_reg <= 1'b1;
          end
        end
        FULL: begin
          // c is left untouched on drain; only the valid flag drops
          if (take && !accept) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_status_stage.sv
// Scoreboard bench for alu_status_stage: directed operand vectors, queue of expected
// {c,status} popped by a negedge monitor on every result take.
module tb_alu_status_stage;
  import alu_pkg::*;

  logic clk;
  logic reset_n;

  alu_status_stage_if #(.WIDTH(16)) bus ();

  alu_status_stage #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] sb[$];
  int n_vec = 0;
  int n_miss = 0;
  int acc_cnt = 0;
  int seen_cnt = 0;
  int to_cnt = 0;
  int to_seen = 0;
  logic stall_chk = 1'b0;
  logic b2b_chk = 1'b0;
  logic end_chk = 1'b0;
  logic end_done = 1'b0;
  logic [15:0] hold_c = '0;
  logic [2:0] hold_st = '0;

  // Single checking process: every comparison and both counters live here
  always @(negedge clk) begin
    logic [18:0] exp_v;
    if (!reset_n) begin
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.c !== 16'h0000 || bus.status !== 3'b000 || bus.in_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL reset: got out_valid=%b c=%h st=%b in_ready=%b, expected 0 0000 000 1",
                 bus.out_valid, bus.c, bus.status, bus.in_ready);
      end
      sb.delete();
      seen_cnt = acc_cnt;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_miss++;
          $display("FAIL take_unexpected: got c=%h st=%b, expected no result", bus.c, bus.status);
        end else begin
          exp_v = sb.pop_front();
          $display("take c=%h st=%b (expected c=%h st=%b)", bus.c, bus.status, exp_v[18:3], exp_v[2:0]);
          if ({bus.c, bus.status} !== exp_v) begin
            n_miss++;
            $display("FAIL result: got c=%h st=%b, expected c=%h st=%b",
                     bus.c, bus.status, exp_v[18:3], exp_v[2:0]);
          end
        end
      end
      if (acc_cnt != seen_cnt) begin
        seen_cnt = acc_cnt;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
          n_miss++;
          $display("FAIL latency: got out_valid=%b, expected 1", bus.out_valid);
        end
      end
      if (stall_chk) begin
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.c !== hold_c || bus.status !== hold_st) begin
          n_miss++;
          $display("FAIL stall: got in_ready=%b out_valid=%b c=%h st=%b, expected 0 1 %h %b",
                   bus.in_ready, bus.out_valid, bus.c, bus.status, hold_c, hold_st);
        end
      end
      if (b2b_chk) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_miss++;
          $display("FAIL b2b_ready: got in_ready=%b, expected 1", bus.in_ready);
        end
      end
      if (to_cnt != to_seen) begin
        to_seen = to_cnt;
        n_vec++;
        n_miss++;
      end
      if (end_chk && !end_done) begin
        end_done = 1'b1;
        n_vec++;
        if (sb.size() != 0) begin
          n_miss++;
          $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input aluop_t op,
                       input logic ld, input logic [15:0] ec, input logic [2:0] es);
    logic acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.ain      = a;
    bus.bin      = b;
    bus.aluop    = op;
    bus.loads    = ld;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) break;
    end
    #1;
    if (!acc) begin
      $display("FAIL accept_timeout: got no accept in 50 cycles, expected accept of a=%h b=%h", a, b);
      to_cnt++;
    end else begin
      sb.push_back({ec, es});
      acc_cnt++;
    end
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ain       = '0;
    bus.bin       = '0;
    bus.aluop     = ALU_ADD;
    bus.loads     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Arithmetic, flags and loads=0 hold
    issue(16'h7FFF, 16'h0001, ALU_ADD, 1'b1, 16'h8000, 3'b011);
    issue(16'h0000, 16'h00FF, ALU_MVN, 1'b1, 16'hFF00, 3'b010);
    issue(16'h1234, 16'h1234, ALU_SUB, 1'b0, 16'h0000, 3'b010);
    issue(16'hF0F0, 16'h0F0F, ALU_AND, 1'b1, 16'h0000, 3'b100);
    issue(16'h8000, 16'h0001, ALU_SUB, 1'b1, 16'h7FFF, 3'b001);
    issue(16'h8000, 16'h8000, ALU_ADD, 1'b1, 16'h0000, 3'b101);

    // Back-to-back, one op per cycle
    b2b_chk = 1'b1;
    issue(16'h0001, 16'h0001, ALU_ADD, 1'b1, 16'h0002, 3'b000);
    issue(16'h0002, 16'h0002, ALU_ADD, 1'b1, 16'h0004, 3'b000);
    issue(16'h0003, 16'h0003, ALU_ADD, 1'b1, 16'h0006, 3'b000);
    issue(16'h0004, 16'h0004, ALU_ADD, 1'b1, 16'h0008, 3'b000);
    b2b_chk = 1'b0;
    idle(2);

    // Output stall with a pending operand set
    bus.out_ready = 1'b0;
    issue(16'h0005, 16'h0007, ALU_SUB, 1'b1, 16'hFFFE, 3'b010);
    hold_c    = 16'hFFFE;
    hold_st   = 3'b010;
    stall_chk = 1'b1;
    fork
      issue(16'hFFFF, 16'h00F0, ALU_AND, 1'b1, 16'h00F0, 3'b000);
      begin
        repeat (5) @(posedge clk);
        #1;
        stall_chk     = 1'b0;
        bus.out_ready = 1'b1;
      end
    join
    idle(2);

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    issue(16'h0005, 16'h0003, ALU_ADD, 1'b1, 16'h0008, 3'b000);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    issue(16'h0001, 16'hFFFF, ALU_ADD, 1'b1, 16'h0000, 3'b100);
    idle(3);

    end_chk = 1'b1;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
